// File: rtl/regfile_pkg.sv
// Shared constants and sizing helper for the integer register file.
package regfile_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  // Address and count fields never shrink below one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sb_popcount.sv
// Combinational popcount of an N-bit vector; zero latency, no flow control.
module sb_popcount #(
  parameter int N = 32,
  localparam int W = $clog2(N + 1)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{(W-1){1'b0}}, vec[i]};
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with NRD bypassed combinational read ports and a busy scoreboard;
// reads/busy are zero latency, dbg_data and busy_cnt are registered one edge later.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = clog2_min1(NREGS),
  localparam int CW = clog2_min1(NREGS + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_dst,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data,
  output logic [CW-1:0]     busy_cnt
);
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             wr_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return int'(a) < NREGS;
  endfunction

  assign wr_ok = wb_en && in_range(wb_addr) && !(ZERO_REG && wb_addr == '0);

  // Flush beats issue beats writeback; issue wins because a new producer owns the register.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_en && in_range(wb_addr)) busy_nxt[wb_addr] = 1'b0;
      if (iss_en && in_range(iss_dst)) busy_nxt[iss_dst] = 1'b1;
    end
    if (ZERO_REG) busy_nxt[0] = 1'b0;
  end

  sb_popcount #(.N(NREGS)) u_popcount (
    .vec(busy_nxt),
    .cnt(cnt_nxt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy     <= '0;
      dbg_data <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) regs[wb_addr] <= wb_data;
      busy     <= busy_nxt;
      dbg_data <= in_range(dbg_addr) ? regs[dbg_addr] : '0;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;
    assign a   = rd_addr[k*AW +: AW];
    assign hit = wr_ok && (wb_addr == a);
    assign rd_data[k*XLEN +: XLEN] = !in_range(a)            ? '0 :
                                     hit                     ? wb_data :
                                     (ZERO_REG && a == '0)   ? '0 : regs[a];
    assign rd_busy[k] = in_range(a) && busy[a] && !hit;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: default build plus a 16x64, 4-port, no-zero-reg build.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  // default instance: XLEN=32, NREGS=32, NRD=2, ZERO_REG=1
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_en, wb_en, flush;
  logic [4:0]  iss_dst, wb_addr, dbg_addr;
  logic [31:0] wb_data, dbg_data;
  logic [5:0]  busy_cnt;
  // parametrised instance: XLEN=64, NREGS=16, NRD=4, ZERO_REG=0
  logic [15:0]  rd_addr2;
  logic [255:0] rd_data2;
  logic [3:0]   rd_busy2;
  logic         iss_en2, wb_en2, flush2;
  logic [3:0]   iss_dst2, wb_addr2, dbg_addr2;
  logic [63:0]  wb_data2, dbg_data2;
  logic [4:0]   busy_cnt2;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp, obs;
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .CLK(clk), .RST(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_dst(iss_dst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy_cnt(busy_cnt)
  );

  regfile_scoreboard #(.XLEN(64), .NREGS(16), .NRD(4), .ZERO_REG(1'b0)) dut2 (
    .CLK(clk), .RST(rst), .rd_addr(rd_addr2), .rd_data(rd_data2), .rd_busy(rd_busy2),
    .iss_en(iss_en2), .iss_dst(iss_dst2), .wb_en(wb_en2), .wb_addr(wb_addr2), .wb_data(wb_data2),
    .flush(flush2), .dbg_addr(dbg_addr2), .dbg_data(dbg_data2), .busy_cnt(busy_cnt2)
  );

  task automatic idle();
    rd_addr = '0; iss_en = 0; iss_dst = '0; wb_en = 0; wb_addr = '0; wb_data = '0;
    flush = 0; dbg_addr = '0;
    rd_addr2 = '0; iss_en2 = 0; iss_dst2 = '0; wb_en2 = 0; wb_addr2 = '0; wb_data2 = '0;
    flush2 = 0; dbg_addr2 = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    iss_en = 1; iss_dst = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    rd_addr = {5'd5, 5'd5}; dbg_addr = 5'd5;
    for (int k = 0; k < 2; k++) exp_q.push_back(64'h0);
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    #1;
    for (int k = 0; k < 2; k++) begin
      obs = 64'(rd_data[k*32 +: 32]); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_rd_data%0d got=%h exp=%h", k, obs, exp); end
    end
    obs = 64'(rd_busy); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_rd_busy got=%h exp=%h", obs, exp); end
    obs = 64'(dbg_data); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_dbg_data got=%h exp=%h", obs, exp); end
    obs = 64'(busy_cnt); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_busy_cnt got=%h exp=%h", obs, exp); end
    rst = 1'b1;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    wb_en = 1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    @(posedge clk);
    mem[5] = 32'hDEADBEEF;
    @(negedge clk);
    idle();
    rd_addr = {5'd0, 5'd5}; dbg_addr = 5'd5;
    exp_q.push_back(64'(mem[5])); exp_q.push_back(64'(mem[5]));
    #1;
    obs = 64'(rd_data[31:0]); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL write_rd_data got=%h exp=%h", obs, exp); end
    @(posedge clk); #1;
    obs = 64'(dbg_data); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL write_dbg_data got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    idle(); iss_en = 1; iss_dst = 5'd7;
    exp_q.push_back(64'd1);
    @(posedge clk); #1;
    obs = 64'(busy_cnt); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL bypass_pre_busy_cnt got=%h exp=%h", obs, exp); end
    @(negedge clk);
    idle(); wb_en = 1; wb_addr = 5'd7; wb_data = 32'h1234; rd_addr = {5'd7, 5'd7};
    exp_q.push_back(64'h1234); exp_q.push_back(64'h1234); exp_q.push_back(64'h0);
    #1;
    for (int k = 0; k < 2; k++) begin
      obs = 64'(rd_data[k*32 +: 32]); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL bypass_rd_data%0d got=%h exp=%h", k, obs, exp); end
    end
    obs = 64'(rd_busy); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL bypass_rd_busy got=%h exp=%h", obs, exp); end
    exp_q.push_back(64'd0);
    @(posedge clk); #1;
    mem[7] = 32'h1234;
    obs = 64'(busy_cnt); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL bypass_post_busy_cnt got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    idle(); wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF;
    iss_en = 1; iss_dst = 5'd0; rd_addr = {5'd0, 5'd0}; dbg_addr = 5'd0;
    exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    #1;
    obs = 64'(rd_data[31:0]); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_bypass got=%h exp=%h", obs, exp); end
    obs = 64'(rd_busy); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_rd_busy_wb got=%h exp=%h", obs, exp); end
    exp_q.push_back(64'd0);
    @(posedge clk); #1;
    obs = 64'(busy_cnt); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_busy_cnt got=%h exp=%h", obs, exp); end
    @(negedge clk);
    idle(); rd_addr = {5'd0, 5'd0}; dbg_addr = 5'd0;
    exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
    #1;
    obs = 64'(rd_data[63:32]); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_rd_data got=%h exp=%h", obs, exp); end
    obs = 64'(rd_busy); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_rd_busy got=%h exp=%h", obs, exp); end
    @(posedge clk); #1;
    obs = 64'(dbg_data); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL zero_dbg_data got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_scoreboard();
    logic [4:0] dst [3];
    dst[0] = 5'd3; dst[1] = 5'd4; dst[2] = 5'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle(); iss_en = 1; iss_dst = dst[i];
      exp_q.push_back(64'(i + 1));
      @(posedge clk); #1;
      obs = 64'(busy_cnt); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL sb_issue%0d busy_cnt got=%h exp=%h", i, obs, exp); end
    end
    @(negedge clk);
    idle(); wb_en = 1; wb_addr = 5'd4; wb_data = 32'h4444;
    exp_q.push_back(64'd2);
    @(posedge clk); #1;
    mem[4] = 32'h4444;
    obs = 64'(busy_cnt); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL sb_wb busy_cnt got=%h exp=%h", obs, exp); end
    @(negedge clk);
    idle(); iss_en = 1; iss_dst = 5'd3; wb_en = 1; wb_addr = 5'd3; wb_data = 32'h3333;
    rd_addr = {5'd4, 5'd3};
    exp_q.push_back(64'b00);
    #1;
    obs = 64'(rd_busy); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL sb_iss_wb rd_busy got=%h exp=%h", obs, exp); end
    exp_q.push_back(64'd2);
    @(posedge clk); #1;
    mem[3] = 32'h3333;
    obs = 64'(busy_cnt); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL sb_iss_wb busy_cnt got=%h exp=%h", obs, exp); end
    @(negedge clk);
    idle(); rd_addr = {5'd4, 5'd3};
    exp_q.push_back(64'b01); exp_q.push_back(64'(mem[3]));
    #1;
    obs = 64'(rd_busy); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL sb_still_busy rd_busy got=%h exp=%h", obs, exp); end
    obs = 64'(rd_data[31:0]); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL sb_wb_data got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    idle(); flush = 1; iss_en = 1; iss_dst = 5'd10; wb_en = 1; wb_addr = 5'd9; wb_data = 32'hAA;
    exp_q.push_back(64'd0);
    @(posedge clk); #1;
    mem[9] = 32'hAA;
    obs = 64'(busy_cnt); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush busy_cnt got=%h exp=%h", obs, exp); end
    @(negedge clk);
    idle(); rd_addr = {5'd10, 5'd9};
    exp_q.push_back(64'b00); exp_q.push_back(64'(mem[9]));
    #1;
    obs = 64'(rd_busy); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush rd_busy got=%h exp=%h", obs, exp); end
    obs = 64'(rd_data[31:0]); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush wb_data got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      d = $urandom;
      idle(); wb_en = 1; wb_addr = 5'(11 + i); wb_data = d;
      rd_addr = {5'd0, 5'(11 + i)}; dbg_addr = 5'(11 + i);
      exp_q.push_back(64'(d)); exp_q.push_back(64'(mem[11 + i]));
      #1;
      obs = 64'(rd_data[31:0]); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b_bypass%0d got=%h exp=%h", i, obs, exp); end
      @(posedge clk); #1;
      mem[11 + i] = d;
      obs = 64'(dbg_data); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b_dbg_prewrite%0d got=%h exp=%h", i, obs, exp); end
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle(); rd_addr = {5'(11 + i), 5'd5}; dbg_addr = 5'(11 + i);
      exp_q.push_back(64'(mem[11 + i])); exp_q.push_back(64'(mem[11 + i]));
      #1;
      obs = 64'(rd_data[63:32]); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b_read%0d got=%h exp=%h", i, obs, exp); end
      @(posedge clk); #1;
      obs = 64'(dbg_data); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL b2b_dbg%0d got=%h exp=%h", i, obs, exp); end
    end
  endtask

  task automatic test_params();
    @(negedge clk);
    idle(); wb_en2 = 1; wb_addr2 = 4'd0; wb_data2 = 64'h1;
    @(posedge clk);
    @(negedge clk);
    idle(); wb_en2 = 1; wb_addr2 = 4'd15; wb_data2 = 64'hCAFE_0000_0000_BEEF;
    rd_addr2 = 16'h0000;
    for (int k = 0; k < 4; k++) exp_q.push_back(64'h1);
    #1;
    for (int k = 0; k < 4; k++) begin
      obs = rd_data2[k*64 +: 64]; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL param_r0_port%0d got=%h exp=%h", k, obs, exp); end
    end
    @(posedge clk);
    @(negedge clk);
    idle(); rd_addr2 = {4'd15, 4'd0, 4'd0, 4'd0}; dbg_addr2 = 4'd15;
    iss_en2 = 1; iss_dst2 = 4'd0;
    exp_q.push_back(64'hCAFE_0000_0000_BEEF); exp_q.push_back(64'd1);
    exp_q.push_back(64'hCAFE_0000_0000_BEEF);
    #1;
    obs = rd_data2[255:192]; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL param_r15 got=%h exp=%h", obs, exp); end
    @(posedge clk); #1;
    obs = 64'(busy_cnt2); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL param_busy_cnt got=%h exp=%h", obs, exp); end
    obs = dbg_data2; exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL param_dbg15 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    idle(); rd_addr2 = 16'h0000;
    exp_q.push_back(64'hF);
    #1;
    obs = 64'(rd_busy2); exp = exp_q.pop_front(); checks++;
    if (obs !== exp) begin errors++; $display("FAIL param_r0_busy got=%h exp=%h", obs, exp); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_flush();
    test_back_to_back();
    test_params();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations got=%0d exp=0", exp_q.size());
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file for the pipelined core, replacing the fixed 32×32 two-read-port file. It provides N combinational read ports with same-cycle writeback bypass and a per-register busy scoreboard for hazard detection. It also has a registered debug read port, so benches can dump architectural state without hierarchical peeks. It sits between decode (read/issue) and writeback in `pipeline_top`.

## Interface
Parameters:
- `XLEN`, 32, register width in bits
- `NREGS`, 32, number of architectural registers (≥2)
- `NRD`, 2, number of read ports (1–4)
- `ZERO_REG`, 1, when 1 register 0 reads as zero, ignores writes and is never busy
- derived: `AW = $clog2(NREGS)`, `CW = $clog2(NREGS+1)`

Ports:
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset, asynchronous, active-low
- `rd_addr`  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
- `rd_data`  out  NRD*XLEN  read data, combinational
- `rd_busy`  out  NRD  scoreboard bit of each read address, combinational
- `iss_en`  in  1  issue of an instruction with a destination register
- `iss_dst`  in  AW  destination register to mark busy
- `wb_en`  in  1  writeback strobe
- `wb_addr`  in  AW  writeback register
- `wb_data`  in  XLEN  writeback value
- `flush`  in  1  pipeline flush; clears all busy bits
- `dbg_addr`  in  AW  debug read address
- `dbg_data`  out  XLEN  debug read data, registered
- `busy_cnt`  out  CW  number of busy registers, registered

## Operation
- Reset (`RST`=0, asynchronous): all registers 0, all busy bits 0, `dbg_data`=0, `busy_cnt`=0. These values are held while `RST` is low.
- Write: on the rising edge with `wb_en`=1, `regs[wb_addr] <= wb_data`. The write is ignored if `ZERO_REG` and `wb_addr`=0. Addresses ≥ `NREGS` are ignored.
- Read port k, `rd_data`:
  - if `wb_en`, `wb_addr`==`rd_addr[k]`, and the write is not suppressed: `wb_data` (bypass)
  - else if `ZERO_REG` and address 0: 0
  - else `regs[rd_addr[k]]`
- Busy, `rd_busy[k]`: `busy[rd_addr[k]]` AND NOT (a valid writeback to the same address this cycle).
- Busy update per edge, with priority from highest to lowest:
  - `flush`=1: every busy bit is cleared and `iss_en` is ignored. A writeback in the same cycle still writes the register.
  - `iss_en`=1: `busy[iss_dst]` <= 1. This overrides a same-cycle writeback clear of the same register, because a new producer owns it.
  - writeback: `busy[wb_addr]` <= 0.
  - `ZERO_REG` forces `busy[0]` to 0 always.
- Debug: `dbg_data <= regs[dbg_addr]`, sampled one edge after the address. It uses pre-write contents, with no bypass.
- `busy_cnt <= popcount(next busy vector)`, so it matches the busy state visible after the same edge.
- Out-of-range `rd_addr`/`dbg_addr` (≥`NREGS`) read 0 and report not busy.

## Timing
- Read and busy ports: zero latency, combinational from `rd_addr`, `wb_*`, and state.
- Write and busy update: visible on reads from the edge that performs them.
- `dbg_data`, `busy_cnt`: 1-cycle latency.
- Asserting reset mid-operation aborts any pending writeback. The first write accepted after release is at the first rising edge with `RST`=1.

## Structure
- Package `regfile_pkg`: default `XLEN`/`NREGS` constants and the function `clog2_min1` used for `AW`/`CW`.
- Sub-module `sb_popcount` (parameter `N`): combinational popcount of the next busy vector, output width `$clog2(N+1)`.
- Register array and busy vector are plain `always_ff` with asynchronous negedge `RST`. Read muxes use a generate loop over `NRD`.

## Test plan
- Reset and write: hold `RST`=0, check all reads, `dbg_data`, and `busy_cnt` are 0. Release reset, write `wb_addr`=5, `wb_data`=0xDEADBEEF. The next cycle `rd_addr[0]`=5 must return 0xDEADBEEF, and `dbg_addr`=5 must return it one edge later.
- Bypass: `wb_en`, `wb_addr`=7, 0x1234, with both read ports on 7 in the same cycle. Both `rd_data` must be 0x1234 combinationally, and `rd_busy`=0 even if 7 was busy.
- Zero register: write 0xFFFF_FFFF to 0 and issue to 0. Register 0 must read 0, `rd_busy`=0, and `busy_cnt` must be unchanged.
- Scoreboard: issue to 3, 4, 9 on consecutive edges, so `busy_cnt` goes 1, 2, 3. Writeback to 4 gives `busy_cnt`=2. Same-cycle issue and writeback to 3 must leave 3 busy.
- Flush: with 3 busy, assert `flush` plus `iss_en` to 10 plus writeback to 9 = 0xAA. Result must be `busy_cnt`=0, 10 not busy, and register 9 = 0xAA.
- Parameters: `NREGS`=16, `NRD`=4, `XLEN`=64, `ZERO_REG`=0. Write and read back register 0 = 0x1 on all four ports, and `rd_addr`=15 must be valid.
